// File: rtl/kb_key_events.sv
// Purpose : turns per-key level inputs into press/release/auto-repeat events queued in a show-ahead FIFO.
// Latency : input change before edge E0 -> pending slot at E0 -> FIFO write at E1 -> ev_valid after E1.
// Backpressure: ev_ready low holds the FIFO head; full FIFO stalls the slots; slot collisions drop (press/release pulse ev_overflow).
//
// Ports:
//   clk, reset          - sole clock, asynchronous active-high reset
//   kb_key_pressed      - per-key level, bit i = key i
//   ev_valid/ev_ready   - FIFO head handshake
//   ev_key, ev_type     - head event: key index, type 01 press / 10 release / 11 repeat
//   ev_overflow         - one-cycle pulse after a press/release was dropped
//   key_state           - kb_key_pressed delayed by one cycle
module kb_key_events #(
    parameter int WIDTH         = 4,
    parameter int DEPTH         = 8,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int REPEAT_EN     = 1,
    parameter int CNT_W         = 25,
    localparam int KEY_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] kb_key_pressed,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [KEY_W-1:0] ev_key,
    output logic [1:0]       ev_type,
    output logic             ev_overflow,
    output logic [WIDTH-1:0] key_state
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // Edge detection against the registered copy.
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] rel;
    logic [WIDTH-1:0] held;

    assign press = kb_key_pressed & ~key_state;
    assign rel   = ~kb_key_pressed & key_state;
    assign held  = kb_key_pressed & key_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_state <= '0;
        end else begin
            key_state <= kb_key_pressed;
        end
    end

    // Hold counters and repeat generation.
    logic [CNT_W-1:0] hold_cnt [WIDTH];
    logic [WIDTH-1:0] rep_seen;   // first repeat already issued for this hold
    logic [WIDTH-1:0] rep_hit;

    always_comb begin
        rep_hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rep_hit[i] = (REPEAT_EN != 0) && held[i] &&
                         (hold_cnt[i] == (rep_seen[i] ? PERIOD_LAST : DELAY_LAST));
        end
    end

    // A key that is not held (idle, just pressed, or just released) keeps its
    // timing at zero, so a fresh press always starts the long first delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                hold_cnt[i] <= '0;
            end
            rep_seen <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!held[i]) begin
                    hold_cnt[i] <= '0;
                    rep_seen[i] <= 1'b0;
                end else if (rep_hit[i]) begin
                    hold_cnt[i] <= '0;
                    rep_seen[i] <= 1'b1;
                end else begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Pending slots and fixed-priority arbiter (lowest index wins).
    logic [WIDTH-1:0] slot_vld;
    logic [1:0]       slot_type [WIDTH];
    logic [KEY_W-1:0] sel_key;
    logic [1:0]       sel_type;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] drain;
    logic [WIDTH-1:0] slot_free;
    logic [WIDTH-1:0] ovf_vec;

    always_comb begin
        sel_key  = '0;
        sel_type = 2'b00;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (slot_vld[i]) begin
                sel_key  = KEY_W'(i);
                sel_type = slot_type[i];
            end
        end
    end

    assign push = (|slot_vld) & ~full;
    assign pop  = ~empty & ev_ready;

    always_comb begin
        drain     = '0;
        slot_free = '0;
        ovf_vec   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            drain[i]     = push && (sel_key == KEY_W'(i));
            // A slot emptied into the FIFO this cycle can take a new event at once.
            slot_free[i] = ~slot_vld[i] | drain[i];
            ovf_vec[i]   = (press[i] | rel[i]) & ~slot_free[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_vld    <= '0;
            ev_overflow <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                slot_type[i] <= 2'b00;
            end
        end else begin
            ev_overflow <= |ovf_vec;
            for (int i = 0; i < WIDTH; i++) begin
                if (press[i] && slot_free[i]) begin
                    slot_vld[i]  <= 1'b1;
                    slot_type[i] <= EV_PRESS;
                end else if (rel[i] && slot_free[i]) begin
                    slot_vld[i]  <= 1'b1;
                    slot_type[i] <= EV_RELEASE;
                end else if (rep_hit[i] && slot_free[i]) begin
                    slot_vld[i]  <= 1'b1;
                    slot_type[i] <= EV_REPEAT;
                end else if (drain[i]) begin
                    slot_vld[i]  <= 1'b0;
                end
            end
        end
    end

    // Show-ahead event FIFO.
    logic [KEY_W-1:0] mem_key  [DEPTH];
    logic [1:0]       mem_type [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_key[wr_ptr]  <= sel_key;
            mem_type[wr_ptr] <= sel_type;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign ev_valid = ~empty;
    assign ev_key   = empty ? '0    : mem_key[rd_ptr];
    assign ev_type  = empty ? 2'b00 : mem_type[rd_ptr];

endmodule

// File: tb/tb_kb_key_events.sv
module tb_kb_key_events;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] kb;
    logic       ev_ready;

    logic       ev_valid, ev_overflow;
    logic [1:0] ev_key, ev_type;
    logic [3:0] key_state;

    logic       ev_valid2, ev_overflow2;
    logic [1:0] ev_key2, ev_type2;
    logic [3:0] key_state2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int b;

    int q_key[$];
    int q_typ[$];
    int q_cyc[$];
    int q2_typ[$];
    int q2_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    kb_key_events #(
        .WIDTH(4), .DEPTH(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .REPEAT_EN(1), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .kb_key_pressed(kb),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_key(ev_key), .ev_type(ev_type),
        .ev_overflow(ev_overflow), .key_state(key_state)
    );

    kb_key_events #(
        .WIDTH(4), .DEPTH(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .REPEAT_EN(0), .CNT_W(4)
    ) dut_norep (
        .clk(clk), .reset(reset), .kb_key_pressed(kb),
        .ev_valid(ev_valid2), .ev_ready(ev_ready), .ev_key(ev_key2), .ev_type(ev_type2),
        .ev_overflow(ev_overflow2), .key_state(key_state2)
    );

    // Accepted events, sampled mid-cycle (the pop happens at the next rising edge).
    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            q_key.push_back(int'(ev_key));
            q_typ.push_back(int'(ev_type));
            q_cyc.push_back(cyc);
        end
        if (!reset && ev_valid2 && ev_ready) begin
            q2_typ.push_back(int'(ev_type2));
            q2_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        q_key.delete();
        q_typ.delete();
        q_cyc.delete();
        q2_typ.delete();
        q2_cyc.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input int idx, input int key, input int typ, input int cy);
        checks++;
        assert (idx < q_key.size()) else begin
            errors++;
            $error("FAIL %s missing event %0d observed count %0d", tag, idx, q_key.size());
        end
        if (idx < q_key.size()) begin
            chk({tag, "_key"}, q_key[idx], key);
            chk({tag, "_type"}, q_typ[idx], typ);
            chk({tag, "_cyc"}, q_cyc[idx], cy);
        end
    endtask

    initial begin
        reset    = 1'b1;
        kb       = 4'b0000;
        ev_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_valid", ev_valid, 0);
        chk("rst_key", ev_key, 0);
        chk("rst_type", ev_type, 0);
        chk("rst_ovf", ev_overflow, 0);
        chk("rst_state", key_state, 0);
        reset = 1'b0;
        tick();

        // Single press then release on key 2
        kb = 4'b0100;
        tick();
        chk("p_state", key_state, 4'b0100);
        chk("p_e0_valid", ev_valid, 0);
        tick();
        chk("p_e1_valid", ev_valid, 1);
        chk("p_e1_key", ev_key, 2);
        chk("p_e1_type", ev_type, 1);
        tick();
        chk("p_e2_valid", ev_valid, 0);
        kb = 4'b0000;
        tick();
        chk("r_e0_valid", ev_valid, 0);
        tick();
        chk("r_e1_valid", ev_valid, 1);
        chk("r_e1_key", ev_key, 2);
        chk("r_e1_type", ev_type, 2);
        tick();
        chk("r_e2_valid", ev_valid, 0);

        // Key 1 held for 20 edges: press, repeats at +8,+12,+16, release
        clear_logs();
        b  = cyc;
        kb = 4'b0010;
        repeat (20) tick();
        kb = 4'b0000;
        repeat (6) tick();
        chk("hold_count", q_key.size(), 5);
        chk_ev("hold_press", 0, 1, 1, b + 2);
        chk_ev("hold_rep1", 1, 1, 3, b + 10);
        chk_ev("hold_rep2", 2, 1, 3, b + 14);
        chk_ev("hold_rep3", 3, 1, 3, b + 18);
        chk_ev("hold_rel", 4, 1, 2, b + 22);
        chk("norep_count", q2_typ.size(), 2);
        if (q2_typ.size() == 2) begin
            chk("norep_press", q2_typ[0], 1);
            chk("norep_press_cyc", q2_cyc[0], b + 2);
            chk("norep_rel", q2_typ[1], 2);
            chk("norep_rel_cyc", q2_cyc[1], b + 22);
        end

        // Simultaneous presses on keys 0,1,3 drain in index order
        clear_logs();
        b  = cyc;
        kb = 4'b1011;
        repeat (5) tick();
        kb = 4'b0000;
        repeat (6) tick();
        chk("multi_count", q_key.size(), 6);
        chk_ev("multi_p0", 0, 0, 1, b + 2);
        chk_ev("multi_p1", 1, 1, 1, b + 3);
        chk_ev("multi_p3", 2, 3, 1, b + 4);
        chk_ev("multi_r0", 3, 0, 2, b + 7);
        chk_ev("multi_r1", 4, 1, 2, b + 8);
        chk_ev("multi_r3", 5, 3, 2, b + 9);

        // Fill FIFO and slots with ev_ready low, then collide on key 0
        clear_logs();
        ev_ready = 1'b0;
        b  = cyc;
        kb = 4'b1111;
        repeat (5) tick();
        chk("full_valid", ev_valid, 1);
        chk("full_head_key", ev_key, 0);
        chk("full_head_type", ev_type, 1);
        kb = 4'b0000;
        tick();
        chk("fill_ovf", ev_overflow, 0);
        kb = 4'b0001;
        tick();
        chk("coll_ovf", ev_overflow, 1);
        chk("stall_head_key", ev_key, 0);
        chk("stall_head_type", ev_type, 1);
        ev_ready = 1'b1;
        tick();
        chk("coll_ovf_end", ev_overflow, 0);
        repeat (7) tick();
        chk("drain_count", q_key.size(), 8);
        chk("drain_empty", ev_valid, 0);
        for (int k = 0; k < 4; k++) begin
            chk_ev("drain_press", k, k, 1, b + 7 + k);
            chk_ev("drain_rel", k + 4, k, 2, b + 11 + k);
        end
        // Repeat of the still-held key 0 drains while its release arrives
        kb = 4'b0000;
        tick();
        chk("same_drain_ovf", ev_overflow, 0);
        chk("rep0_valid", ev_valid, 1);
        chk("rep0_key", ev_key, 0);
        chk("rep0_type", ev_type, 3);
        tick();
        chk("rel0_valid", ev_valid, 1);
        chk("rel0_key", ev_key, 0);
        chk("rel0_type", ev_type, 2);
        tick();
        chk("after_empty", ev_valid, 0);

        // Reset mid-operation with queued and pending events
        ev_ready = 1'b0;
        kb = 4'b0111;
        repeat (4) tick();
        chk("pre_rst_valid", ev_valid, 1);
        kb = 4'b0100;
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", ev_valid, 0);
        chk("mid_rst_key", ev_key, 0);
        chk("mid_rst_type", ev_type, 0);
        chk("mid_rst_state", key_state, 0);
        ev_ready = 1'b1;
        tick();
        tick();
        chk("rst_hold_valid", ev_valid, 0);
        clear_logs();
        b = cyc;
        reset = 1'b0;
        repeat (6) tick();
        chk("post_rst_count", q_key.size(), 1);
        chk_ev("post_rst_press", 0, 2, 1, b + 2);
        chk("post_rst_ovf", ev_overflow, 0);

        kb = 4'b0000;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
